// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared constants and helpers for the MEMC SRAM port arbiter.
package sram_arb_pkg;

  localparam int ADDR_W = 9;
  localparam int BANKS  = 4;
  localparam int DATA_W = 8;
  localparam int BUS_W  = BANKS * DATA_W;
  localparam int RD_LAT = 3;
  localparam int AGE_W  = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_arb_rd_pipe.sv
// rtl/sram_arb_rd_pipe.sv - read-return valid shift pipe with rd_data capture in the last stage.
module sram_arb_rd_pipe #(
  parameter int RD_LAT = sram_arb_pkg::RD_LAT,
  parameter int WIDTH  = sram_arb_pkg::BUS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_i,
  input  logic [WIDTH-1:0] sram_q_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             busy_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [WIDTH-1:0]  data_q;

  // Stage RD_LAT-2 is the cycle the SRAM output register holds the read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= {valid_q[RD_LAT-2:0], issue_i};
      if (valid_q[RD_LAT-2]) begin
        data_q <= sram_q_i;
      end
    end
  end

  assign rd_valid_o = valid_q[RD_LAT-1];
  assign rd_data_o  = data_q;
  assign busy_o     = |valid_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester arbiter for the four 512x8 MEMC SRAM banks.
// Optional statistics counters are built when SRAM_ARB_STATS_EN is defined.
module sram_port_arbiter #(
  parameter int ADDR_W   = sram_arb_pkg::ADDR_W,
  parameter int BANKS    = sram_arb_pkg::BANKS,
  parameter int DATA_W   = sram_arb_pkg::DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_req,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [BANKS*DATA_W-1:0]   wr_data,
  output logic                      wr_gnt,
  input  logic                      rd_req,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_gnt,
  output logic                      rd_valid,
  output logic [BANKS*DATA_W-1:0]   rd_data,
  output logic                      sram_cen,
  output logic                      sram_wen,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [BANKS*DATA_W-1:0]   sram_d,
  input  logic [BANKS*DATA_W-1:0]   sram_q,
  output logic                      busy,
  output logic [15:0]               stat_rd_cnt,
  output logic [15:0]               stat_wr_cnt,
  output logic [15:0]               stat_stall_cnt
);

  import sram_arb_pkg::*;

  localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_WAIT);

  gnt_e                   grant;
  logic [AGE_W-1:0]       age_q, age_d;
  logic                   cen_q, wen_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [BANKS*DATA_W-1:0] d_q;
  logic                   pipe_busy;

  // Reads win by default; a write that has waited MAX_WAIT read grants wins instead.
  always_comb begin
    grant = GNT_NONE;
    if (wr_req && (!rd_req || age_q >= MAX_AGE)) begin
      grant = GNT_WR;
    end else if (rd_req) begin
      grant = GNT_RD;
    end
  end

  assign wr_gnt = (grant == GNT_WR);
  assign rd_gnt = (grant == GNT_RD);

  always_comb begin
    age_d = age_q;
    if (!wr_req || wr_gnt) begin
      age_d = '0;
    end else if (age_q < MAX_AGE) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q  <= '0;
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
      addr_q <= '0;
      d_q    <= '0;
    end else begin
      age_q <= age_d;
      cen_q <= ~(wr_gnt | rd_gnt);
      wen_q <= ~wr_gnt;
      if (wr_gnt) begin
        addr_q <= wr_addr;
        d_q    <= wr_data;
      end else if (rd_gnt) begin
        addr_q <= rd_addr;
      end
    end
  end

  assign sram_cen  = cen_q;
  assign sram_wen  = wen_q;
  assign sram_addr = addr_q;
  assign sram_d    = d_q;

  sram_arb_rd_pipe #(
    .RD_LAT (RD_LAT),
    .WIDTH  (BANKS*DATA_W)
  ) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_i    (rd_gnt),
    .sram_q_i   (sram_q),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .busy_o     (pipe_busy)
  );

  assign busy = wr_req | rd_req | pipe_busy;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (wr_req & ~wr_gnt) | (rd_req & ~rd_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_gnt) rd_cnt_q    <= sat_inc16(rd_cnt_q);
      if (wr_gnt) wr_cnt_q    <= sat_inc16(wr_cnt_q);
      if (stall)  stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign stat_rd_cnt    = rd_cnt_q;
  assign stat_wr_cnt    = wr_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_rd_cnt    = '0;
  assign stat_wr_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter with a behavioural SRAM.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req;
  logic [8:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic        wr_gnt, rd_gnt, rd_valid;
  logic [31:0] rd_data;
  logic        sram_cen, sram_wen;
  logic [8:0]  sram_addr;
  logic [31:0] sram_d, sram_q;
  logic        busy;
  logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_gnt         (wr_gnt),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_gnt         (rd_gnt),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .sram_cen       (sram_cen),
    .sram_wen       (sram_wen),
    .sram_addr      (sram_addr),
    .sram_d         (sram_d),
    .sram_q         (sram_q),
    .busy           (busy),
    .stat_rd_cnt    (stat_rd_cnt),
    .stat_wr_cnt    (stat_wr_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  // Synchronous single-port SRAM: output register updates only on a read access.
  logic [31:0] mem [0:511];
  logic [31:0] q_r;
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_d;
      else           q_r <= mem[sram_addr];
    end
  end
  assign sram_q = q_r;

  logic [31:0] ref_mem [0:511];
  logic [31:0] exp_q[$];
  int          gnt_cyc_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      gnt_cyc_q.delete();
    end else begin
      if (rd_gnt) gnt_cyc_q.push_back(cyc);
      if (rd_valid) begin
        if (exp_q.size() == 0 || gnt_cyc_q.size() == 0) begin
          check("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
          check("rd_latency", 32'(cyc - gnt_cyc_q.pop_front()), 32'd3);
        end
      end
    end
  end

  task automatic step(input logic w, input logic [8:0] wa, input logic [31:0] wd,
                      input logic r, input logic [8:0] ra,
                      input logic ewg, input logic erg, input string name);
    wr_req = w; wr_addr = wa; wr_data = wd;
    rd_req = r; rd_addr = ra;
    @(negedge clk);
    check(name, {30'd0, wr_gnt, rd_gnt}, {30'd0, ewg, erg});
    if (ewg) ref_mem[wa] = wd;
    if (erg) exp_q.push_back(ref_mem[ra]);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, 32'd0, 1'b0, 9'd0, 1'b0, 1'b0, "idle_gnt");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_gnt",   {31'd0, wr_gnt},   32'd0);
    check("rst_rd_gnt",   {31'd0, rd_gnt},   32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data",  rd_data,           32'd0);
    check("rst_cen",      {31'd0, sram_cen}, 32'd1);
    check("rst_wen",      {31'd0, sram_wen}, 32'd1);
    check("rst_addr",     {23'd0, sram_addr}, 32'd0);
    check("rst_d",        sram_d,            32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_stats",    {stat_rd_cnt, stat_wr_cnt | stat_stall_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write then read of address 5.
    step(1'b1, 9'd5, 32'hA1B2C3D4, 1'b0, 9'd0, 1'b1, 1'b0, "wr5_gnt");
    check("wr5_issue", {sram_cen, sram_wen, 21'd0, sram_addr}, {2'b00, 21'd0, 9'd5});
    check("wr5_d", sram_d, 32'hA1B2C3D4);
    step(1'b0, 9'd0, 32'd0, 1'b1, 9'd5, 1'b0, 1'b1, "rd5_gnt");
    check("rd5_issue", {sram_cen, sram_wen, 21'd0, sram_addr}, {2'b01, 21'd0, 9'd5});
    check("rd5_busy", {31'd0, busy}, 32'd1);
    idle(5);
    check("idle_cen", {31'd0, sram_cen}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Aging: continuous reads, write promoted on the 5th cycle, twice in a row.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b1, 9'(20 + k), 32'h11223344 + 32'(k), 1'b1, 9'd5,
             i == 4, i != 4, "age_gnt");
      end
    end
    step(1'b0, 9'd0, 32'd0, 1'b1, 9'd20, 1'b0, 1'b1, "rd20_gnt");
    step(1'b0, 9'd0, 32'd0, 1'b1, 9'd21, 1'b0, 1'b1, "rd21_gnt");
    idle(5);

    // Burst of 8 writes then 8 back-to-back reads.
    for (int i = 0; i < 8; i++)
      step(1'b1, 9'(i), {4{8'(i)}} ^ 32'h5A00A500, 1'b0, 9'd0, 1'b1, 1'b0, "bw_gnt");
    for (int i = 0; i < 8; i++)
      step(1'b0, 9'd0, 32'd0, 1'b1, 9'(i), 1'b0, 1'b1, "br_gnt");
    idle(5);

    // Write then read of the top address on consecutive cycles.
    step(1'b1, 9'd511, 32'hDEADBEEF, 1'b0, 9'd0, 1'b1, 1'b0, "w511_gnt");
    step(1'b0, 9'd0, 32'd0, 1'b1, 9'd511, 1'b0, 1'b1, "r511_gnt");
    idle(5);

    // Reset one cycle after a read grant: the read must never return.
    step(1'b0, 9'd0, 32'd0, 1'b1, 9'd5, 1'b0, 1'b1, "rdrst_gnt");
    rst_n = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("midrst_cen",   {31'd0, sram_cen}, 32'd1);
    check("midrst_valid", {31'd0, rd_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_valid2", {31'd0, rd_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // Post-reset traffic: 3 reads, 2 writes, 2 stalled cycles.
    step(1'b0, 9'd0, 32'd0, 1'b1, 9'd5, 1'b0, 1'b1, "prst_rd_gnt");
    step(1'b1, 9'd30, 32'hCAFE0001, 1'b1, 9'd5, 1'b0, 1'b1, "st_rd1");
    step(1'b1, 9'd30, 32'hCAFE0001, 1'b1, 9'd5, 1'b0, 1'b1, "st_rd2");
    step(1'b1, 9'd30, 32'hCAFE0001, 1'b0, 9'd0, 1'b1, 1'b0, "st_wr1");
    step(1'b1, 9'd31, 32'hCAFE0002, 1'b0, 9'd0, 1'b1, 1'b0, "st_wr2");
    idle(1);
`ifdef SRAM_ARB_STATS_EN
    check("stat_rd",    {16'd0, stat_rd_cnt},    32'd3);
    check("stat_wr",    {16'd0, stat_wr_cnt},    32'd2);
    check("stat_stall", {16'd0, stat_stall_cnt}, 32'd2);
`else
    check("stat_rd",    {16'd0, stat_rd_cnt},    32'd0);
    check("stat_wr",    {16'd0, stat_wr_cnt},    32'd0);
    check("stat_stall", {16'd0, stat_stall_cnt}, 32'd0);
`endif
    step(1'b0, 9'd0, 32'd0, 1'b1, 9'd30, 1'b0, 1'b1, "rd30_gnt");
    step(1'b0, 9'd0, 32'd0, 1'b1, 9'd31, 1'b0, 1'b1, "rd31_gnt");
    idle(6);
    check("drain_exp", 32'(exp_q.size()), 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
